// File: rtl/lsb_serializer.sv
// lsb_serializer: accepts a WIDTH-bit word over valid/ready and shifts it out LSB first, one bit per clock.
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   load_valid  producer has a word on load_data
//   load_data   parallel word, captured only on an accepted transfer
//   load_ready  combinational; high when idle or on the last bit of the word in flight
//   a           serial data bit, LSB first
//   bit_valid   a carries a real data bit this cycle
//   frame_start high with bit 0 of each word
//   frame_last  high with bit WIDTH-1 of each word
module lsb_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             a,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_last
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_start;
  logic             r_last;
  logic             w_accept;
  assign load_ready  = reset && (r_state == IDLE || (r_state == SHIFT && r_last));
  assign w_accept    = load_valid && load_ready;
  // Zeros shift in from the top, so the register is already empty when the word ends.
  assign a           = r_shreg[0];
  assign bit_valid   = r_state == SHIFT;
  assign frame_start = r_start;
  assign frame_last  = r_last;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_start <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_cnt   <= '0;
      r_shreg <= load_data;
      r_start <= 1'b1;
      r_last  <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_shreg <= r_shreg >> 1;
      r_start <= 1'b0;
      r_state <= (r_cnt == LAST) ? IDLE : SHIFT;
      r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      r_last  <= (r_cnt == PENULT);
    end
  end
endmodule

// File: tb/tb_lsb_serializer.sv
// tb_lsb_serializer: scoreboard bench for lsb_serializer at WIDTH=8.
module tb_lsb_serializer;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, a, bit_valid, frame_start, frame_last;
  logic [4:0]   q[$];
  logic [4:0]   exp_v, obs_v;
  int           n_cmp = 0;
  int           n_err = 0;

  lsb_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .a(a), .bit_valid(bit_valid),
    .frame_start(frame_start), .frame_last(frame_last)
  );

  always #5 clk = ~clk;

  // expected vector per bit: {a, bit_valid, frame_start, frame_last, load_ready}
  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++)
      q.push_back({d[i], 1'b1, i == 0, i == W - 1, i == W - 1});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load_valid = 1'b1;
    load_data = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
      n_cmp++;
      if (obs_v !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_held cyc%0d: got %b want 00000", c, obs_v);
      end
    end
    load_valid = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
      n_cmp++;
      if (obs_v !== 5'b00001) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: got %b want 00001", c, obs_v);
      end
    end
  endtask

  task automatic test_single();
    logic       seen;
    logic       sb;
    logic [W-1:0] neg;
    int         k;
    seen = 1'b0;
    neg = '0;
    k = 0;
    load_valid = 1'b1;
    load_data = 8'h06;
    push_word(8'h06);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      load_data = 8'hEE;
      exp_v = (q.size() != 0) ? q.pop_front() : 5'b00001;
      obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL single cyc%0d: got %b want %b", c, obs_v, exp_v);
      end
      if (bit_valid && k < W) begin
        // serial two's-complement negator re-armed on frame_start
        sb = frame_start ? 1'b0 : seen;
        neg[k] = a ^ sb;
        seen = sb | a;
        k++;
      end
    end
    n_cmp++;
    if (neg !== 8'hFA) begin
      n_err++;
      $display("FAIL negator: got %h want fa", neg);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    acc = 0;
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 8'h01;
    push_word(8'h01);
    acc = 1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      exp_v = (q.size() != 0) ? q.pop_front() : 5'b00001;
      obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL b2b cyc%0d: got %b want %b", c, obs_v, exp_v);
      end
      load_valid = acc < 2;
      load_data = 8'h80;
      if (load_valid && exp_v[0]) begin
        push_word(load_data);
        acc++;
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_ignore();
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 8'h3C;
    push_word(8'h3C);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      exp_v = (q.size() != 0) ? q.pop_front() : 5'b00001;
      obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL ignore cyc%0d: got %b want %b", c, obs_v, exp_v);
      end
      load_valid = (c == 3);
      load_data = (c == 3) ? 8'hFF : 8'h00;
      if (load_valid && exp_v[0]) push_word(load_data);
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 8'hA5;
    push_word(8'hA5);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      exp_v = q.pop_front();
      obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL mid_pre cyc%0d: got %b want %b", c, obs_v, exp_v);
      end
    end
    reset = 1'b0;
    #1;
    obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
    n_cmp++;
    if (obs_v !== 5'b00000) begin
      n_err++;
      $display("FAIL mid_reset: got %b want 00000", obs_v);
    end
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_v = (q.size() != 0) ? q.pop_front() : 5'b00001;
      obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL mid_post cyc%0d: got %b want %b", c, obs_v, exp_v);
      end
      load_valid = (c == 4);
      load_data = 8'hC3;
      if (load_valid && exp_v[0]) push_word(load_data);
    end
    load_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_v = (q.size() != 0) ? q.pop_front() : 5'b00001;
      obs_v = {a, bit_valid, frame_start, frame_last, load_ready};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL mid_tail cyc%0d: got %b want %b", c, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lsb_serializer.md
Name: lsb_serializer

Overview:
Parallel-to-serial front end for the bit-serial arithmetic datapath. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB first, on `a`. Its output feeds the downstream bit-serial two's-complement negator directly. `frame_start` marks bit 0 of every word so the downstream stage can re-arm its carry state per word. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 8, word length in bits; legal range is WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
load_valid  input  1  producer has a word on load_data
load_data  input  WIDTH  parallel word; sampled only on an accepted transfer
load_ready  output  1  serializer can accept a word this cycle
a  output  1  serial data bit, LSB first
bit_valid  output  1  a carries a real data bit this cycle
frame_start  output  1  high with bit 0 of each word
frame_last  output  1  high with bit WIDTH-1 of each word

Behaviour:
- Handshake
  - A transfer is accepted on a rising edge where load_valid && load_ready.
  - When not accepted, load_data is ignored.
  - load_valid may stay high across transfers.
- Registered outputs: a, bit_valid, frame_start and frame_last are all flops.
- load_ready is combinational:
  - It equals reset && (state==IDLE || (state==SHIFT && frame_last)).
  - It is forced to 0 while reset is asserted.
- States:
  - IDLE: no word in flight.
  - SHIFT: word in flight; a bit counter cnt (width clog2(WIDTH)) counts 0..WIDTH-1.
- Transitions:
  - IDLE, accept -> SHIFT, cnt=0.
  - SHIFT, cnt<WIDTH-1 -> SHIFT, cnt+1.
  - SHIFT, cnt==WIDTH-1, accept -> SHIFT, cnt=0 (new word, no bubble).
  - SHIFT, cnt==WIDTH-1, no accept -> IDLE.
- Latency:
  - Accept at edge k gives bit 0 on `a` in the cycle after edge k (frame_start=1, bit_valid=1).
  - Bit i appears i cycles later.
  - frame_last is high in the cycle of bit WIDTH-1.
- Shift register:
  - Loaded with load_data on accept.
  - Shifts right by 1 each SHIFT cycle.
  - a = shreg[0].
- frame_start and frame_last are each 1-cycle pulses per word, both qualified by bit_valid.
- Idle outputs: a=0, bit_valid=0, frame_start=0, frame_last=0.
- Reset values (asynchronous, on reset low):
  - state=IDLE, cnt=0, shift register=0.
  - a=0, bit_valid=0, frame_start=0, frame_last=0, load_ready=0.
  - After reset deasserts, load_ready=1 combinationally.
- Reset mid-frame: the word is discarded immediately and all outputs go to their reset values. No partial bits are emitted after reset release.
- load_valid during SHIFT with cnt<WIDTH-1: not accepted, no effect. The producer must hold its word.
- Simultaneous last bit and accept: the current last bit is emitted that cycle, and the new word's bit 0 follows on the next cycle.

Test Plan:
- Reset low, then high; no valid -> load_ready=1; a, bit_valid, frame_start and frame_last all 0 indefinitely.
- Single word 0x06 (WIDTH=8) accepted at edge 0 ->
  - Cycles 1..8: a = 0,1,1,0,0,0,0,0; bit_valid=1.
  - frame_start only at cycle 1; frame_last only at cycle 8.
  - load_ready low in cycles 1..7, high in cycle 8.
  - IDLE from cycle 9.
- load_valid held high with 0x01 then 0x80 ->
  - 16 contiguous bit_valid cycles; a = 1,0×7 then 0×7,1.
  - frame_start at cycles 1 and 9.
- load_valid pulsed with 0xFF at cycle 3 of a word in flight -> not accepted; current word bits unchanged; no extra frame.
- reset asserted at cycle 4 of word 0xA5 -> all outputs 0 within the reset cycle; after release, output stays idle until a new accept.
- Chain into the bit-serial negator, with its state re-armed on frame_start; feed 0x06 -> negator output bits 0,1,0,1,1,1,1,1 (0xFA).
